// File: rtl/vga_scan_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_scan_engine                                                 |
// | Purpose  : Parametrised VGA raster generator. Issues linear read requests  |
// |            to a VRAM read port, realigns sync/enable with the returned     |
// |            pixel data and drives registered RGB, HS and VS.                |
// | Ports    : vga_clk      pixel clock (only clock)                           |
// |            clr          asynchronous active-high reset                     |
// |            en           run request                                        |
// |            rd_en        VRAM read enable                                   |
// |            rd_addr      linear VRAM address                                |
// |            rd_data      VRAM data {r,g,b}, RD_LAT clocks after rd_en       |
// |            r, g, b      pixel colour                                       |
// |            hs, vs       sync outputs (polarity from HS_POL / VS_POL)       |
// |            de           display enable, aligned with r/g/b                 |
// |            frame_start  one-clock pulse on the first visible pixel         |
// |            busy         high while running or draining a frame             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_scan_engine #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int COLOR_W    = 4,
   parameter int SCALE_LOG2 = 0,
   parameter int RD_LAT     = 1,
   parameter int ADDR_W     = 19
) (
   input  logic                   vga_clk,
   input  logic                   clr,
   input  logic                   en,
   output logic                   rd_en,
   output logic [ADDR_W-1:0]      rd_addr,
   input  logic [3*COLOR_W-1:0]   rd_data,
   output logic [COLOR_W-1:0]     r,
   output logic [COLOR_W-1:0]     g,
   output logic [COLOR_W-1:0]     b,
   output logic                   hs,
   output logic                   vs,
   output logic                   de,
   output logic                   frame_start,
   output logic                   busy
);

   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_HW      = $clog2(c_H_TOTAL);
   localparam int c_VW      = $clog2(c_V_TOTAL);

   localparam logic [c_HW-1:0]   c_H_LAST     = c_HW'(c_H_TOTAL - 1);
   localparam logic [c_VW-1:0]   c_V_LAST     = c_VW'(c_V_TOTAL - 1);
   localparam logic [c_HW-1:0]   c_H_ACT      = c_HW'(H_ACTIVE);
   localparam logic [c_VW-1:0]   c_V_ACT      = c_VW'(V_ACTIVE);
   localparam logic [c_HW-1:0]   c_HS_START   = c_HW'(H_ACTIVE + H_FP);
   localparam logic [c_HW-1:0]   c_HS_END     = c_HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [c_VW-1:0]   c_VS_START   = c_VW'(V_ACTIVE + V_FP);
   localparam logic [c_VW-1:0]   c_VS_END     = c_VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [c_VW-1:0]   c_V_MASK     = c_VW'((1 << SCALE_LOG2) - 1);
   localparam logic [ADDR_W-1:0] c_SRC_W      = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [c_HW-1:0]     h_cnt_q, h_cnt_d;
   logic [c_VW-1:0]     v_cnt_q, v_cnt_d;
   logic [ADDR_W-1:0]   line_base_q, line_base_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                hs_iss_q, hs_iss_d;
   logic                vs_iss_q, vs_iss_d;
   logic                fs_iss_q, fs_iss_d;
   logic                busy_q;
   logic [RD_LAT:0]     de_pipe_q;
   logic [RD_LAT:0]     fs_pipe_q;
   logic [RD_LAT:0]     hs_pipe_q;
   logic [RD_LAT:0]     vs_pipe_q;
   logic [3*COLOR_W-1:0] rgb_q;
   logic                w_frame_end;
   logic                w_running_d;

   assign w_frame_end = (h_cnt_q == c_H_LAST) && (v_cnt_q == c_V_LAST);

   // Control state and raster counters.
   always_comb begin
      state_d     = state_q;
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      line_base_d = line_base_q;

      case (state_q)
         S_IDLE:  if (en) state_d = S_RUN;
         S_RUN:   if (!en) state_d = S_DRAIN;
         S_DRAIN: begin
            if (en) state_d = S_RUN;
            else if (w_frame_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q == S_IDLE) begin
         h_cnt_d     = '0;
         v_cnt_d     = '0;
         line_base_d = '0;
      end else if (h_cnt_q == c_H_LAST) begin
         h_cnt_d = '0;
         if (v_cnt_q == c_V_LAST) begin
            v_cnt_d     = '0;
            line_base_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + 1'b1;
            // A new source row begins only when the replicated-line group wraps.
            if ((v_cnt_d & c_V_MASK) == '0) line_base_d = line_base_q + c_SRC_W;
         end
      end else begin
         h_cnt_d = h_cnt_q + 1'b1;
      end
   end

   // Issue-stage values are derived from the next counter state so that the
   // registered rd_en/rd_addr describe the position held in the counters.
   always_comb begin
      w_running_d = (state_d != S_IDLE);
      rd_en_d     = w_running_d && (h_cnt_d < c_H_ACT) && (v_cnt_d < c_V_ACT);
      rd_addr_d   = rd_en_d ? (line_base_d + ADDR_W'(h_cnt_d >> SCALE_LOG2)) : rd_addr_q;
      hs_iss_d    = w_running_d && (h_cnt_d >= c_HS_START) && (h_cnt_d <= c_HS_END);
      vs_iss_d    = w_running_d && (v_cnt_d >= c_VS_START) && (v_cnt_d <= c_VS_END);
      fs_iss_d    = rd_en_d && (h_cnt_d == '0) && (v_cnt_d == '0);
   end

   always_ff @(posedge vga_clk or posedge clr) begin
      if (clr) begin
         state_q     <= S_IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         line_base_q <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         hs_iss_q    <= 1'b0;
         vs_iss_q    <= 1'b0;
         fs_iss_q    <= 1'b0;
         busy_q      <= 1'b0;
         de_pipe_q   <= '0;
         fs_pipe_q   <= '0;
         hs_pipe_q   <= {(RD_LAT+1){~HS_POL}};
         vs_pipe_q   <= {(RD_LAT+1){~VS_POL}};
         rgb_q       <= '0;
      end else begin
         state_q     <= state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         line_base_q <= line_base_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         hs_iss_q    <= hs_iss_d;
         vs_iss_q    <= vs_iss_d;
         fs_iss_q    <= fs_iss_d;
         busy_q      <= (state_d != S_IDLE);
         // Stage k of each pipe is valid k+1 clocks after issue; the last
         // stage lines up with the pixel register below.
         de_pipe_q   <= {de_pipe_q[RD_LAT-1:0], rd_en_q};
         fs_pipe_q   <= {fs_pipe_q[RD_LAT-1:0], fs_iss_q};
         hs_pipe_q   <= {hs_pipe_q[RD_LAT-1:0], hs_iss_q ? HS_POL : ~HS_POL};
         vs_pipe_q   <= {vs_pipe_q[RD_LAT-1:0], vs_iss_q ? VS_POL : ~VS_POL};
         // Stage RD_LAT-1 is the enable that belongs to the word on rd_data now.
         rgb_q       <= de_pipe_q[RD_LAT-1] ? rd_data : '0;
      end
   end

   assign rd_en       = rd_en_q;
   assign rd_addr     = rd_addr_q;
   assign r           = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign g           = rgb_q[2*COLOR_W-1:COLOR_W];
   assign b           = rgb_q[COLOR_W-1:0];
   assign hs          = hs_pipe_q[RD_LAT];
   assign vs          = vs_pipe_q[RD_LAT];
   assign de          = de_pipe_q[RD_LAT];
   assign frame_start = fs_pipe_q[RD_LAT];
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_scan_engine                                              |
// | Purpose  : Self-checking bench for vga_scan_engine on a 14x7 raster.       |
// |            A: RD_LAT=1, B: SCALE_LOG2=1, C: RD_LAT=3, D: high-active sync. |
// |            Each VRAM port echoes its own address back as pixel data.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_scan_engine;

   logic clk = 1'b0;
   logic clr;
   logic en;
   always #5 clk = ~clk;

   logic a_rd_en, b_rd_en, c_rd_en, d_rd_en;
   logic [18:0] a_addr, b_addr, c_addr, d_addr;
   logic [11:0] a_data, b_data, c_data, d_data;
   logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b, d_r, d_g, d_b;
   logic a_hs, a_vs, a_de, a_fs, a_busy;
   logic b_hs, b_vs, b_de, b_fs, b_busy;
   logic c_hs, c_vs, c_de, c_fs, c_busy;
   logic d_hs, d_vs, d_de, d_fs, d_busy;

   vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .SCALE_LOG2(0),
      .RD_LAT(1), .ADDR_W(19)) u_a (
      .vga_clk(clk), .clr(clr), .en(en), .rd_en(a_rd_en), .rd_addr(a_addr), .rd_data(a_data),
      .r(a_r), .g(a_g), .b(a_b), .hs(a_hs), .vs(a_vs), .de(a_de), .frame_start(a_fs), .busy(a_busy));

   vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .SCALE_LOG2(1),
      .RD_LAT(1), .ADDR_W(19)) u_b (
      .vga_clk(clk), .clr(clr), .en(en), .rd_en(b_rd_en), .rd_addr(b_addr), .rd_data(b_data),
      .r(b_r), .g(b_g), .b(b_b), .hs(b_hs), .vs(b_vs), .de(b_de), .frame_start(b_fs), .busy(b_busy));

   vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .SCALE_LOG2(0),
      .RD_LAT(3), .ADDR_W(19)) u_c (
      .vga_clk(clk), .clr(clr), .en(en), .rd_en(c_rd_en), .rd_addr(c_addr), .rd_data(c_data),
      .r(c_r), .g(c_g), .b(c_b), .hs(c_hs), .vs(c_vs), .de(c_de), .frame_start(c_fs), .busy(c_busy));

   vga_scan_engine #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .SCALE_LOG2(0),
      .RD_LAT(1), .ADDR_W(19)) u_d (
      .vga_clk(clk), .clr(clr), .en(en), .rd_en(d_rd_en), .rd_addr(d_addr), .rd_data(d_data),
      .r(d_r), .g(d_g), .b(d_b), .hs(d_hs), .vs(d_vs), .de(d_de), .frame_start(d_fs), .busy(d_busy));

   // Address-echo VRAM models: data appears RD_LAT clocks after the request.
   logic [11:0] dl_a, dl_b, dl_d;
   logic [11:0] dl_c[3];
   always @(posedge clk) begin
      dl_a    <= a_addr[11:0];
      dl_b    <= b_addr[11:0];
      dl_d    <= d_addr[11:0];
      dl_c[0] <= c_addr[11:0];
      dl_c[1] <= dl_c[0];
      dl_c[2] <= dl_c[1];
   end
   assign a_data = dl_a;
   assign b_data = dl_b;
   assign c_data = dl_c[2];
   assign d_data = dl_d;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference raster for the 14x7 geometry: state 0 idle, 1 run, 2 drain.
   int m_state = 0, m_h = 0, m_v = 0, m_addr_a = 0, m_addr_b = 0;
   bit m_act = 0, m_hs = 0, m_vs = 0, m_fs = 0;
   bit hist_act[8], hist_hs[8], hist_vs[8], hist_fs[8];
   int hist_addr_a[8], hist_addr_b[8];
   bit gap_on = 0;
   int gaps   = 0;

   task automatic model_reset();
      m_state = 0; m_h = 0; m_v = 0; m_addr_a = 0; m_addr_b = 0;
      m_act = 0; m_hs = 0; m_vs = 0; m_fs = 0;
   endtask

   task automatic flush_hist();
      for (int k = 0; k < 8; k++) begin
         hist_act[k] = 0; hist_hs[k] = 0; hist_vs[k] = 0; hist_fs[k] = 0;
         hist_addr_a[k] = 0; hist_addr_b[k] = 0;
      end
   endtask

   task automatic model_update();
      bit fend;
      if (clr) begin
         model_reset();
      end else begin
         fend = (m_h == 13) && (m_v == 6);
         if (m_state != 0) begin
            if (m_h == 13) begin
               m_h = 0;
               m_v = (m_v == 6) ? 0 : m_v + 1;
            end else begin
               m_h++;
            end
         end
         case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 2;
            default: begin
               if (en) m_state = 1;
               else if (fend) m_state = 0;
            end
         endcase
         m_act = (m_state != 0) && (m_h < 8) && (m_v < 4);
         if (m_act) begin
            m_addr_a = m_v * 8 + m_h;
            m_addr_b = (m_v / 2) * 4 + m_h / 2;
         end
         m_hs = (m_state != 0) && (m_h >= 10) && (m_h <= 12);
         m_vs = (m_state != 0) && (m_v == 5);
         m_fs = m_act && (m_h == 0) && (m_v == 0);
      end
   endtask

   task automatic check_inst(input string nm, input int lat, input bit pol, input bit sc,
                             input logic o_rd_en, input logic [18:0] o_addr, input logic [11:0] o_rgb,
                             input logic o_de, input logic o_hs, input logic o_vs, input logic o_fs,
                             input logic o_busy);
      int idx, k, e_addr;
      bit e_act, e_hs, e_vs, e_fs;
      check({nm, ".rd_en"}, o_rd_en, m_act);
      check({nm, ".rd_addr"}, o_addr, sc ? m_addr_b : m_addr_a);
      check({nm, ".busy"}, o_busy, m_state != 0);
      idx = cyc - lat - 1;
      e_act = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_addr = 0;
      if (idx >= 0) begin
         k = idx % 8;
         e_act = hist_act[k]; e_hs = hist_hs[k]; e_vs = hist_vs[k]; e_fs = hist_fs[k];
         e_addr = sc ? hist_addr_b[k] : hist_addr_a[k];
      end
      check({nm, ".de"}, o_de, e_act);
      check({nm, ".rgb"}, o_rgb, e_act ? (e_addr & 32'hFFF) : 0);
      check({nm, ".hs"}, o_hs, e_hs ? pol : !pol);
      check({nm, ".vs"}, o_vs, e_vs ? pol : !pol);
      check({nm, ".frame_start"}, o_fs, e_fs);
   endtask

   task automatic step();
      int k;
      @(posedge clk);
      model_update();
      k = cyc % 8;
      hist_act[k] = m_act; hist_hs[k] = m_hs; hist_vs[k] = m_vs; hist_fs[k] = m_fs;
      hist_addr_a[k] = m_addr_a; hist_addr_b[k] = m_addr_b;
      #1;
      check_inst("A", 1, 1'b0, 1'b0, a_rd_en, a_addr, {a_r, a_g, a_b}, a_de, a_hs, a_vs, a_fs, a_busy);
      check_inst("B", 1, 1'b0, 1'b1, b_rd_en, b_addr, {b_r, b_g, b_b}, b_de, b_hs, b_vs, b_fs, b_busy);
      check_inst("C", 3, 1'b0, 1'b0, c_rd_en, c_addr, {c_r, c_g, c_b}, c_de, c_hs, c_vs, c_fs, c_busy);
      check_inst("D", 1, 1'b1, 1'b0, d_rd_en, d_addr, {d_r, d_g, d_b}, d_de, d_hs, d_vs, d_fs, d_busy);
      if (gap_on && !a_busy) gaps++;
      cyc++;
   endtask

   task automatic wait_pos(input int h, input int v, input string tag);
      int guard = 0;
      while (!(m_h == h && m_v == v && m_state != 0) && guard < 300) begin
         step();
         guard++;
      end
      if (guard >= 300) check({"timeout.", tag}, 0, 1);
   endtask

   int exp_b_line0[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   int first_de_a, first_de_c, first_fs_c, hs_low_a, vs_low_a, hs_high_d, fs_cnt_c;
   bit prev_busy;

   initial begin
      clr = 1'b1;
      en  = 1'b0;
      flush_hist();
      repeat (3) step();
      check("rst.A.hs", a_hs, 1'b1);
      check("rst.A.vs", a_vs, 1'b1);
      check("rst.D.hs", d_hs, 1'b0);
      check("rst.D.vs", d_vs, 1'b0);
      check("rst.A.rd_addr", a_addr, 0);
      clr = 1'b0;
      repeat (3) step();
      check("idle.A.busy", a_busy, 1'b0);

      // Two full frames with en held high.
      en = 1'b1;
      first_de_a = -1; first_de_c = -1; first_fs_c = -1;
      hs_low_a = 0; vs_low_a = 0; hs_high_d = 0; fs_cnt_c = 0;
      for (int i = 0; i < 198; i++) begin
         step();
         if (i < 8) check("scale.B.line0", b_addr, exp_b_line0[i]);
         if (i == 9)  check("hold.A.rd_addr", a_addr, 7);
         if (i == 14) check("scale.B.line1", b_addr, 0);
         if (i == 28) check("scale.B.line2", b_addr, 4);
         if (i == 42) check("scale.B.line3", b_addr, 4);
         if (a_de && first_de_a < 0) first_de_a = i;
         if (c_de && first_de_c < 0) first_de_c = i;
         if (c_fs && first_fs_c < 0) first_fs_c = i;
         if (i >= 2) begin
            if (!a_hs) hs_low_a++;
            if (!a_vs) vs_low_a++;
            if (d_hs)  hs_high_d++;
         end
         if (c_fs) fs_cnt_c++;
      end
      check("lat.A.first_de", first_de_a, 2);
      check("lat.C.first_de", first_de_c, 4);
      check("lat.C.first_fs", first_fs_c, 4);
      check("lat.C.fs_count", fs_cnt_c, 2);
      check("sync.A.hs_low", hs_low_a, 42);
      check("sync.A.vs_low", vs_low_a, 28);
      check("sync.D.hs_high", hs_high_d, 42);

      // Drop en at v=2, re-raise during drain: raster must not stall.
      wait_pos(0, 2, "v2a");
      en = 1'b0;
      gap_on = 1'b1;
      gaps = 0;
      wait_pos(0, 4, "v4");
      check("drain.A.busy", a_busy, 1'b1);
      en = 1'b1;
      wait_pos(0, 2, "v2b");
      gap_on = 1'b0;
      check("drain.no_gap", gaps, 0);

      // Drop en again and let the frame finish.
      en = 1'b0;
      begin
         int guard = 0;
         prev_busy = 1'b0;
         while (m_state != 0 && guard < 300) begin
            prev_busy = a_busy;
            step();
            guard++;
         end
         if (guard >= 300) check("timeout.idle", 0, 1);
      end
      check("drain.busy_before", prev_busy, 1'b1);
      check("drain.busy_after", a_busy, 1'b0);
      check("drain.rd_en_after", a_rd_en, 1'b0);
      repeat (5) step();
      check("idle.A.de", a_de, 1'b0);
      check("idle.A.rgb", {a_r, a_g, a_b}, 0);
      check("idle.A.hs", a_hs, 1'b1);
      check("idle.A.vs", a_vs, 1'b1);
      check("idle.D.hs", d_hs, 1'b0);
      check("idle.A.rd_addr_hold", a_addr, 31);

      // Asynchronous clear in the middle of a line.
      en = 1'b1;
      wait_pos(5, 1, "clrpos");
      check("preclr.A.de", a_de, 1'b1);
      clr = 1'b1;
      #1;
      check("clr.A.rd_addr", a_addr, 0);
      check("clr.A.rd_en", a_rd_en, 1'b0);
      check("clr.A.de", a_de, 1'b0);
      check("clr.A.rgb", {a_r, a_g, a_b}, 0);
      check("clr.A.hs", a_hs, 1'b1);
      check("clr.A.busy", a_busy, 1'b0);
      check("clr.B.rd_addr", b_addr, 0);
      check("clr.C.de", c_de, 1'b0);
      check("clr.D.hs", d_hs, 1'b0);
      model_reset();
      flush_hist();
      repeat (2) step();
      clr = 1'b0;
      step();
      check("restart.A.rd_en", a_rd_en, 1'b1);
      check("restart.A.rd_addr", a_addr, 0);
      step();
      check("restart.A.rd_addr1", a_addr, 1);
      repeat (100) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan engine: generates raster timing, issues linear read requests to a dual-port VRAM read port, and drives registered RGB, HS and VS. It is the next-generation video path for the display subsystem. Compared with the fixed 640x480 controller it adds:

- configurable timing and sync polarity
- integer pixel up-scaling
- a configurable VRAM read latency with pipeline-aligned sync
- clean run/stop control

Display geometry is free of hard-coded constants.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal front porch, sync, back porch (clocks)
- V_ACTIVE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porches and sync (lines)
- HS_POL / VS_POL, 0 / 0: sync active level (0 = active-low)
- COLOR_W, 4: bits per colour channel
- SCALE_LOG2, 0: up-scale factor 2^SCALE_LOG2, legal 0..2
- RD_LAT, 1: VRAM read latency in clocks, legal 1..4
- ADDR_W, 19: VRAM address width

Ports:
- vga_clk  in  1  pixel clock; the only clock
- clr  in  1  asynchronous active-high reset
- en  in  1  run request
- rd_en  out  1  VRAM read enable
- rd_addr  out  ADDR_W  linear VRAM address
- rd_data  in  3*COLOR_W  VRAM data {r,g,b}, valid RD_LAT clocks after rd_en
- r, g, b  out  COLOR_W each  pixel colour
- hs, vs  out  1  sync outputs
- de  out  1  display-enable, aligned with r/g/b
- frame_start  out  1  one-clock pulse aligned with the first visible pixel of a frame
- busy  out  1  high in RUN or DRAIN

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Horizontal phase order: active, FP, sync, BP. Vertical order is the same.
- Counters: h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1.
  - h_cnt wraps to 0 at H_TOTAL-1 and increments v_cnt.
  - v_cnt wraps to 0 at V_TOTAL-1.
- Source geometry: SRC_W = H_ACTIVE>>SCALE_LOG2.
  - rd_addr = (v_cnt>>SCALE_LOG2)*SRC_W + (h_cnt>>SCALE_LOG2), row-major.
  - No multiplier: a line-base register adds SRC_W at the start of each line where the low SCALE_LOG2 bits of v_cnt wrap to 0.
  - The line base clears at v_cnt wrap.
  - rd_addr holds its last value outside the active area.
- rd_en = RUN/DRAIN and h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- State machine:
  - IDLE: counters held at 0, rd_en 0.
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1 (no disturbance to counters).
  - DRAIN -> IDLE at the end of the frame, i.e. h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
- Outputs in IDLE, after the pipeline empties:
  - r/g/b = 0, de = 0
  - hs = ~HS_POL, vs = ~VS_POL
  - frame_start = 0
- r/g/b are forced to 0 whenever the delayed de is 0, regardless of rd_data.
- Reset (clr asserted at any time, including mid-frame) has immediate effect:
  - state = IDLE, counters = 0, line base = 0, pipeline cleared
  - all outputs take their IDLE values
  - rd_addr = 0, busy = 0

## Timing
- Issue stage at clock t: counters, rd_en and rd_addr are registered outputs of cycle t.
- rd_data is sampled at t+RD_LAT.
- r/g/b, de, hs, vs and frame_start are all registered and appear at t+RD_LAT+1.
  - hs, vs, de and frame_start travel an RD_LAT+1-deep shift pipeline so they stay aligned with the pixel.
- Issue-side sync windows:
  - hs active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs active for v_cnt in the equivalent vertical window, held for whole lines
- First active pixel after leaving IDLE: issued on the clock after en is sampled high; visible RD_LAT+1 clocks later with frame_start=1.
- busy is registered and follows the state; it drops on the clock after DRAIN -> IDLE.

## Test plan
- Small geometry (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, RD_LAT=1), en held high, rd_data = address echo:
  - H_TOTAL=14, V_TOTAL=7
  - hs low for 3 clocks every 14; vs low for 14 clocks every 98
  - rgb walks 0..31 in row-major order, delayed 2 clocks from rd_addr
- Same geometry with SCALE_LOG2=1:
  - rd_addr sequence per line is 0,0,1,1,2,2,3,3
  - lines 0 and 1 share base 0; lines 2 and 3 share base 4
- RD_LAT=3:
  - de, hs and first pixel shift by exactly 2 clocks relative to RD_LAT=1
  - frame_start coincides with pixel address 0
- en dropped mid-frame at v_cnt=2:
  - the frame completes, busy falls one clock after the last counter state, outputs go idle
  - en re-raised during DRAIN keeps the raster continuous with no gap
- clr pulsed at h_cnt=5, v_cnt=1:
  - outputs are idle and rd_addr=0 in the same cycle
  - after release with en=1, scanning restarts at address 0
- HS_POL=1, VS_POL=1: sync pulses are high-active and idle level is 0.
